// File: rtl/stage4_mem_writeback.sv
// stage4_mem_writeback: memory access over req/ack with timeout watchdog, then a one-cycle register writeback pulse
module stage4_mem_writeback #(
  parameter int TIMEOUT = 16,
  parameter int REGSEL_W = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Valid,
  input  logic [15:0]         ResIn,
  input  logic                isZero,
  input  logic [15:0]         StoreData,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                MemToReg,
  input  logic                RegWrite,
  input  logic [REGSEL_W-1:0] RegDest,
  output logic                Stall,
  output logic                MemReq,
  output logic                MemWE,
  output logic [15:0]         MemAddr,
  output logic [15:0]         MemWData,
  input  logic [15:0]         MemRData,
  input  logic                MemAck,
  output logic                WBWrite,
  output logic [REGSEL_W-1:0] WBDest,
  output logic [15:0]         WBData,
  output logic                ZeroOut,
  output logic                MemErr
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, stateNext;
  logic [TW-1:0] timer;
  logic [15:0] resQ, mdr;
  logic [REGSEL_W-1:0] regDestQ;
  logic memWriteQ, memToRegQ, regWriteQ;
  logic accept, isMem, timeUp;
  always_comb begin
    accept = Valid & (state == IDLE);
    isMem = MemRead | MemWrite;
    timeUp = (timer == TLAST) & ~MemAck;
    stateNext = (state == IDLE) ? ((accept & isMem) ? REQ : IDLE) :
                (state == REQ)  ? ((MemAck | timeUp) ? DONE : REQ) : IDLE;
    Stall = (state != IDLE);
    MemReq = (state == REQ);
    MemWE = MemReq & memWriteQ;
  end
  // The ack edge both captures MDR and arms the DONE-cycle writeback, so load data reaches WBData without an extra cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      timer <= '0;
      mdr <= '0;
      resQ <= '0;
      regDestQ <= '0;
      memWriteQ <= 1'b0;
      memToRegQ <= 1'b0;
      regWriteQ <= 1'b0;
      MemAddr <= '0;
      MemWData <= '0;
      WBWrite <= 1'b0;
      WBDest <= '0;
      WBData <= '0;
      ZeroOut <= 1'b0;
      MemErr <= 1'b0;
    end else begin
      state <= stateNext;
      WBWrite <= 1'b0;
      if (accept) begin
        resQ <= ResIn;
        regDestQ <= RegDest;
        memWriteQ <= MemWrite;
        memToRegQ <= MemToReg;
        regWriteQ <= RegWrite;
        ZeroOut <= isZero;
        timer <= '0;
        if (isMem) begin
          MemAddr <= ResIn;
          MemWData <= StoreData;
        end else if (RegWrite) begin
          WBWrite <= 1'b1;
          WBData <= ResIn;
          WBDest <= RegDest;
        end
      end
      if (state == REQ) begin
        if (MemAck) begin
          if (!memWriteQ) mdr <= MemRData;
          if (regWriteQ && !memWriteQ) begin
            WBWrite <= 1'b1;
            WBData <= memToRegQ ? MemRData : resQ;
            WBDest <= regDestQ;
          end
        end else begin
          timer <= (timer == TLAST) ? timer : timer + 1'b1;
          if (timer == TLAST) MemErr <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_stage4_mem_writeback.sv
// tb_stage4_mem_writeback: randomized ops against a transaction-level model; writebacks checked by a scoreboard monitor
module tb_stage4_mem_writeback;
  localparam int TIMEOUT = 16;
  logic CLK = 1'b0, Reset = 1'b1, Valid = 1'b0, isZero = 1'b0;
  logic MemRead = 1'b0, MemWrite = 1'b0, MemToReg = 1'b0, RegWrite = 1'b0, MemAck = 1'b0;
  logic [15:0] ResIn = '0, StoreData = '0, MemRData = '0;
  logic [3:0] RegDest = '0;
  logic Stall, MemReq, MemWE, WBWrite, ZeroOut, MemErr;
  logic [15:0] MemAddr, MemWData, WBData;
  logic [3:0] WBDest;
  int total = 0, passed = 0;
  bit errExp = 1'b0;
  logic [19:0] wbQ[$];

  stage4_mem_writeback #(.TIMEOUT(TIMEOUT), .REGSEL_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Valid(Valid), .ResIn(ResIn), .isZero(isZero),
    .StoreData(StoreData), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .RegDest(RegDest), .Stall(Stall), .MemReq(MemReq), .MemWE(MemWE),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .WBWrite(WBWrite), .WBDest(WBDest), .WBData(WBData), .ZeroOut(ZeroOut), .MemErr(MemErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (WBWrite !== 1'b0) begin
      if (wbQ.size() == 0) begin
        total++;
        $display("FAIL wbUnexpected: got WBWrite=%b dest=%0d data=%h, expected no writeback", WBWrite, WBDest, WBData);
      end else chk("wb{dest,data}", {12'h0, WBDest, WBData}, {12'h0, wbQ.pop_front()});
    end
  end

  // ackAt: REQ cycle (1-based) in which memory acks; 0 or beyond TIMEOUT means no ack in time
  task automatic doOp(input logic [15:0] res, input logic [15:0] sd, input logic ld, input logic st,
                      input logic m2r, input logic rw, input logic z, input logic [3:0] dest,
                      input int ackAt, input logic [15:0] rdata);
    bit isMem, acked;
    int last, reqs, n;
    isMem = ld | st;
    acked = (ackAt >= 1) && (ackAt <= TIMEOUT);
    ResIn = res; StoreData = sd; MemRead = ld; MemWrite = st; MemToReg = m2r;
    RegWrite = rw; isZero = z; RegDest = dest; Valid = 1'b1;
    n = 0;
    while (Stall !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (Stall !== 1'b0) begin
      chk("acceptBound", {31'h0, Stall}, 32'h0);
      Valid = 1'b0;
      return;
    end
    if (!isMem && rw) wbQ.push_back({dest, res});
    if (isMem && !st && rw && acked) wbQ.push_back({dest, m2r ? rdata : res});
    if (isMem && !acked) errExp = 1'b1;
    @(negedge CLK);
    Valid = 1'b0;
    chk("zeroOut", {31'h0, ZeroOut}, {31'h0, z});
    if (!isMem) begin
      chk("aluStall", {31'h0, Stall}, 32'h0);
      chk("aluWBWrite", {31'h0, WBWrite}, {31'h0, rw});
      chk("aluMemReq", {31'h0, MemReq}, 32'h0);
    end else begin
      last = acked ? ackAt : TIMEOUT;
      reqs = 0;
      chk("memWE", {31'h0, MemWE}, {31'h0, st});
      chk("memAddr", {16'h0, MemAddr}, {16'h0, res});
      chk("memWData", {16'h0, MemWData}, {16'h0, sd});
      for (int k = 1; k <= last; k++) begin
        reqs += int'(MemReq === 1'b1);
        MemAck = (k == ackAt);
        MemRData = (k == ackAt) ? rdata : 16'($urandom);
        @(negedge CLK);
      end
      MemAck = 1'b0;
      chk("reqCycles", reqs, last);
      chk("reqDropped", {31'h0, MemReq}, 32'h0);
      chk("doneStall", {31'h0, Stall}, 32'h1);
      chk("memErr", {31'h0, MemErr}, {31'h0, errExp});
    end
  endtask

  initial begin
    int kind, ack;
    repeat (2) @(negedge CLK);
    chk("rstCtl", {26'h0, Stall, MemReq, MemWE, WBWrite, ZeroOut, MemErr}, 32'h0);
    chk("rstMem", {MemAddr, MemWData}, 32'h0);
    chk("rstWB", {12'h0, WBDest, WBData}, 32'h0);
    Reset = 1'b0;
    @(negedge CLK);
    doOp(16'h1234, 16'h0, 0, 0, 0, 1, 0, 4'd3, 0, 16'h0);
    doOp(16'h0040, 16'h0, 1, 0, 1, 1, 1, 4'd5, 2, 16'hBEEF);
    doOp(16'h0010, 16'h00AA, 0, 1, 0, 1, 0, 4'd2, 1, 16'h0);
    doOp(16'h0077, 16'h0, 1, 0, 1, 1, 0, 4'd6, 0, 16'h0);
    doOp(16'h5555, 16'h0, 0, 0, 0, 1, 1, 4'd7, 0, 16'h0);
    chk("memErrSticky", {31'h0, MemErr}, 32'h1);
    doOp(16'h0300, 16'h0, 1, 0, 1, 1, 0, 4'd8, TIMEOUT, 16'hCAFE);
    Valid = 1'b0;
    while (Stall !== 1'b0) @(negedge CLK);
    ResIn = 16'h0044; MemRead = 1'b1; MemWrite = 1'b0; MemToReg = 1'b1; RegWrite = 1'b1; RegDest = 4'd9;
    Valid = 1'b1;
    @(negedge CLK);
    Valid = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    chk("rstMidReq", {29'h0, MemReq, Stall, MemErr}, 32'h0);
    errExp = 1'b0;
    Reset = 1'b0;
    MemAck = 1'b1;
    MemRData = 16'hDEAD;
    @(negedge CLK);
    MemAck = 1'b0;
    chk("lateAckIgnored", {30'h0, MemReq, Stall}, 32'h0);
    @(negedge CLK);
    doOp(16'h0123, 16'h0, 1, 0, 1, 1, 0, 4'd1, 3, 16'h4321);
    doOp(16'h0F0F, 16'h0, 0, 0, 0, 1, 0, 4'd4, 0, 16'h0);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      ack = $urandom_range(0, 6) == 0 ? 0 : $urandom_range(1, 20);
      doOp(16'($urandom), 16'($urandom), kind == 1, kind == 2, 1'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom), ack, 16'($urandom));
    end
    repeat (3) @(negedge CLK);
    chk("wbQueueDrained", wbQ.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
